// File: rtl/down_counter_sched_pkg.sv
// Shared definitions for the down-counter run scheduler: state encoding and
// the widths of the requester, shadow-counter and pass-counter fields.
package down_counter_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int NREQ   = 2;
  localparam int CNT_W  = 3;
  localparam int PASS_W = 2;

endpackage

// File: rtl/down_counter_sched_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie, the requester that was
// not served last wins. The winner is returned one-hot, or all zero if there is no request.
module rr_pick2
  import down_counter_sched_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic            i_last,
  output logic [NREQ-1:0] o_win
);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    o_win = '0;
    case (i_req)
      2'b01:   o_win = 2'b01;
      2'b10:   o_win = 2'b10;
      2'b11:   o_win = i_last ? 2'b01 : 2'b10;
      default: o_win = '0;
    endcase
  end

endmodule

// File: rtl/down_counter_sched.sv
// Grants a shared 3-bit down counter to one of two requesters for PASSES full
// passes, checks the counter's carry-out against a shadow count and pulses done.
module down_counter_sched
  import down_counter_sched_pkg::*;
#(
  parameter int PASSES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            co,
  output logic [NREQ-1:0] gnt,
  output logic            cnt,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic            err
);

  state_t              r_state;
  state_t              w_next;
  logic [NREQ-1:0]     r_gnt;
  logic                r_last;
  logic [CNT_W-1:0]    r_shadow;
  logic [PASS_W-1:0]   r_pass;
  logic                r_err;
  logic [NREQ-1:0]     w_win;
  logic                w_final;
  logic                w_exp_co;

  rr_pick2 u_pick (
    .i_req  (req),
    .i_last (r_last),
    .o_win  (w_win)
  );

  assign w_final  = (r_shadow == '1) && (r_pass == PASS_W'(PASSES - 1));
  assign w_exp_co = (r_state == RUN) && (r_shadow == '1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|req) w_next = RUN;
      RUN:     if (w_final) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_last resets to 1 so that requester 0 wins the first tie.
  // NOTE: only these few control flops are reset; there is no memory here to clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt    <= '0;
      r_last   <= 1'b1;
      r_shadow <= '0;
      r_pass   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (co != w_exp_co) r_err <= 1'b1;
      case (r_state)
        IDLE: r_gnt <= w_win;
        RUN: begin
          r_shadow <= r_shadow + 1'b1;
          if (r_shadow == '1) r_pass <= w_final ? '0 : r_pass + 1'b1;
        end
        DONE: begin
          r_gnt  <= '0;
          r_last <= r_gnt[1];
        end
        default: r_gnt <= '0;
      endcase
    end
  end

  always_comb begin
    cnt  = (r_state == RUN);
    busy = (r_state != IDLE);
    gnt  = r_gnt;
    done = (r_state == DONE) ? r_gnt : '0;
    err  = r_err;
  end

endmodule

// File: tb/tb_down_counter_sched.sv
// Bench for down_counter_sched: PASSES=1 and PASSES=3 instances share the
// stimulus, each drives its own model of the shared down counter, and both are checked against a run-position reference model.
module tb_down_counter_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic       co_inj = 1'b0;

  logic [1:0] gnt_a, gnt_b, done_a, done_b;
  logic [1:0] cnt_v, busy_v, err_v, co_v;
  logic [2:0] dc_a, dc_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int         m_pos  [2];
  logic [1:0] m_gnt  [2];
  int         m_last [2];
  logic       m_err  [2];

  always #5 clk = ~clk;

  // The external shared down counters, reset by the same rst as the DUTs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc_a <= 3'd0;
      dc_b <= 3'd0;
    end else begin
      if (cnt_v[0]) dc_a <= dc_a - 3'd1;
      if (cnt_v[1]) dc_b <= dc_b - 3'd1;
    end
  end

  assign co_v[0] = (cnt_v[0] && (dc_a == 3'd1)) ^ co_inj;
  assign co_v[1] = (cnt_v[1] && (dc_b == 3'd1)) ^ co_inj;

  down_counter_sched #(.PASSES(1)) dut_a (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .co   (co_v[0]),
    .gnt  (gnt_a),
    .cnt  (cnt_v[0]),
    .done (done_a),
    .busy (busy_v[0]),
    .err  (err_v[0])
  );

  down_counter_sched #(.PASSES(3)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .co   (co_v[1]),
    .gnt  (gnt_b),
    .cnt  (cnt_v[1]),
    .done (done_b),
    .busy (busy_v[1]),
    .err  (err_v[1])
  );

  function automatic int passes(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i]  = -1;
      m_gnt[i]  = 2'b00;
      m_last[i] = 1;
      m_err[i]  = 1'b0;
    end
  endtask

  // Position -1 is idle, 0..8P-1 are the counting cycles, 8P is the done cycle.
  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int         len;
      logic [1:0] g;
      logic [1:0] d;
      string      p;
      len = 8 * passes(i);
      g   = (i == 0) ? gnt_a : gnt_b;
      d   = (i == 0) ? done_a : done_b;
      p   = $sformatf("p%0d", passes(i));
      check({p, ".gnt"},  32'(g), 32'((m_pos[i] >= 0) ? m_gnt[i] : 2'b00));
      check({p, ".cnt"},  32'(cnt_v[i]), 32'((m_pos[i] >= 0) && (m_pos[i] < len)));
      check({p, ".done"}, 32'(d), 32'((m_pos[i] == len) ? m_gnt[i] : 2'b00));
      check({p, ".busy"}, 32'(busy_v[i]), 32'(m_pos[i] >= 0));
      check({p, ".err"},  32'(err_v[i]), 32'(m_err[i]));
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int   len;
      int   w;
      logic exp_co;
      len    = 8 * passes(i);
      exp_co = (m_pos[i] >= 0) && (m_pos[i] < len) && ((m_pos[i] % 8) == 7);
      if (co_v[i] != exp_co) m_err[i] = 1'b1;
      if (m_pos[i] == -1) begin
        if (req != 2'b00) begin
          if (req == 2'b11) w = (m_last[i] == 1) ? 0 : 1;
          else              w = req[1] ? 1 : 0;
          m_gnt[i] = (w == 0) ? 2'b01 : 2'b10;
          m_pos[i] = 0;
        end
      end else if (m_pos[i] == len) begin
        m_last[i] = m_gnt[i][1] ? 1 : 0;
        m_pos[i]  = -1;
      end else begin
        m_pos[i]++;
      end
    end
  endtask

  // Called on a falling edge: check, drive the next inputs, advance the model.
  task automatic tick(input logic [1:0] r, input logic inj);
    compare_all();
    req    = r;
    co_inj = inj;
    #1;
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    co_inj = 1'b0;
    rst    = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single one-cycle request from requester 0.
    tick(2'b01, 1'b0);
    repeat (40) tick(2'b00, 1'b0);

    // Both requesting: grants alternate with one idle cycle between runs.
    repeat (60) tick(2'b11, 1'b0);
    repeat (30) tick(2'b00, 1'b0);

    // Reset in the middle of a run, then a clean run afterwards.
    tick(2'b01, 1'b0);
    repeat (4) tick(2'b00, 1'b0);
    do_reset();
    tick(2'b01, 1'b0);
    repeat (30) tick(2'b00, 1'b0);

    // Random requests, including drops during runs.
    repeat (400) tick(2'($urandom_range(0, 3)), 1'b0);
    repeat (30) tick(2'b00, 1'b0);

    // Spurious co in the fifth counting cycle: err latches, run length unchanged.
    tick(2'b10, 1'b0);
    repeat (4) tick(2'b00, 1'b0);
    tick(2'b00, 1'b1);
    repeat (30) tick(2'b00, 1'b0);

    // Random requests with occasional co corruption after a fresh reset.
    do_reset();
    repeat (150) tick(2'($urandom_range(0, 3)), 1'b0);
    repeat (150) tick(2'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0));

    compare_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
